// File: rtl/rgb2ycbcr_csc.sv
// Frame-locked RGB -> YCbCr colour-space conversion on the 27-bit display-port bus.
// Define YCBCR422_EN for 4:2:2 chroma output (one extra stage, latency 4).
module rgb2ycbcr_csc #(
    parameter int LAT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        range_sel,
    input  logic [26:0] DPi,
    output logic [26:0] DPo,
    output logic        active
);
    logic vs_prev;
    logic rng;
    logic rise;
    logic act_eff;
    logic rng_eff;

    assign rise    = DPi[26] & ~vs_prev;
    // The pixel presented with the vsync edge already uses the newly latched mode.
    assign act_eff = rise ? enable : active;
    assign rng_eff = rise ? range_sel : rng;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_prev <= 1'b1;
            active  <= 1'b0;
            rng     <= 1'b0;
        end else begin
            vs_prev <= DPi[26];
            if (rise) begin
                active <= enable;
                rng    <= range_sel;
            end
        end
    end

    logic signed [9:0]  coef [9];
    logic signed [9:0]  px   [3];
    logic signed [19:0] prod [9];

    always_comb begin
        px[0] = {2'b00, DPi[23:16]};
        px[1] = {2'b00, DPi[15:8]};
        px[2] = {2'b00, DPi[7:0]};
        if (rng_eff) begin
            coef[0] = 10'sd66;   coef[1] = 10'sd129;  coef[2] = 10'sd25;
            coef[3] = -10'sd38;  coef[4] = -10'sd74;  coef[5] = 10'sd112;
            coef[6] = 10'sd112;  coef[7] = -10'sd94;  coef[8] = -10'sd18;
        end else begin
            coef[0] = 10'sd77;   coef[1] = 10'sd150;  coef[2] = 10'sd29;
            coef[3] = -10'sd43;  coef[4] = -10'sd85;  coef[5] = 10'sd128;
            coef[6] = 10'sd128;  coef[7] = -10'sd107; coef[8] = -10'sd21;
        end
        for (int i = 0; i < 9; i++) begin
            prod[i] = coef[i] * px[i % 3];
        end
    end

    logic signed [19:0] s1_prod [9];
    logic               s1_act;
    logic               s1_rng;
    logic signed [19:0] s2_sum  [3];
    logic               s2_act;
    logic               s2_rng;
    logic [26:0]        dp_pipe [LAT-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 9; i++) s1_prod[i] <= '0;
            for (int k = 0; k < 3; k++) s2_sum[k] <= '0;
            for (int i = 0; i < LAT - 1; i++) dp_pipe[i] <= '0;
            s1_act <= 1'b0;
            s1_rng <= 1'b0;
            s2_act <= 1'b0;
            s2_rng <= 1'b0;
        end else begin
            for (int i = 0; i < 9; i++) s1_prod[i] <= prod[i];
            for (int k = 0; k < 3; k++) begin
                s2_sum[k] <= s1_prod[3*k] + s1_prod[3*k+1] + s1_prod[3*k+2] + 20'sd128;
            end
            dp_pipe[0] <= DPi;
            for (int i = 1; i < LAT - 1; i++) dp_pipe[i] <= dp_pipe[i-1];
            s1_act <= act_eff;
            s1_rng <= rng_eff;
            s2_act <= s1_act;
            s2_rng <= s1_rng;
        end
    end

    function automatic logic [7:0] clamp8(input logic signed [19:0] v,
                                          input logic [7:0] lo,
                                          input logic [7:0] hi);
        if (v < $signed({12'd0, lo}))
            clamp8 = lo;
        else if (v > $signed({12'd0, hi}))
            clamp8 = hi;
        else
            clamp8 = v[7:0];
    endfunction

    logic signed [19:0] y_v;
    logic signed [19:0] cb_v;
    logic signed [19:0] cr_v;
    logic [23:0]        ycc;
    logic [26:0]        out_c;

    always_comb begin
        y_v   = (s2_sum[0] >>> 8) + (s2_rng ? 20'sd16 : 20'sd0);
        cb_v  = (s2_sum[1] >>> 8) + 20'sd128;
        cr_v  = (s2_sum[2] >>> 8) + 20'sd128;
        ycc   = {clamp8(y_v,  s2_rng ? 8'd16 : 8'd0, s2_rng ? 8'd235 : 8'd255),
                 clamp8(cb_v, s2_rng ? 8'd16 : 8'd0, s2_rng ? 8'd240 : 8'd255),
                 clamp8(cr_v, s2_rng ? 8'd16 : 8'd0, s2_rng ? 8'd240 : 8'd255)};
        out_c = s2_act ? {dp_pipe[LAT-2][26:24], ycc} : dp_pipe[LAT-2];
    end

`ifdef YCBCR422_EN
    logic [26:0] s3_dp;
    logic        s3_act;
    logic        ph;
    logic [7:0]  cr_even;
    logic [8:0]  cb_avg;
    logic [8:0]  cr_avg;
    logic [7:0]  chroma;

    // Even pixels look ahead at the next pixel's Cb; a lone last pixel pairs with itself.
    always_comb begin
        cb_avg = {1'b0, s3_dp[15:8]}
               + (out_c[24] ? {1'b0, ycc[15:8]} : {1'b0, s3_dp[15:8]}) + 9'd1;
        cr_avg = {1'b0, cr_even} + {1'b0, s3_dp[7:0]} + 9'd1;
        chroma = ph ? 8'(cr_avg >> 1) : 8'(cb_avg >> 1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s3_dp   <= '0;
            s3_act  <= 1'b0;
            ph      <= 1'b0;
            cr_even <= '0;
            DPo     <= '0;
        end else begin
            s3_dp  <= out_c;
            s3_act <= s2_act;
            ph     <= s3_dp[24] ? ~ph : 1'b0;
            if (!ph) cr_even <= s3_dp[7:0];
            DPo <= s3_act ? {s3_dp[26:24], s3_dp[23:16], chroma, 8'd0} : s3_dp;
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) DPo <= '0;
        else     DPo <= out_c;
    end
`endif

endmodule

// File: tb/tb_rgb2ycbcr_csc.sv
// Scoreboard bench for rgb2ycbcr_csc: directed colours, frame-locked mode switching,
// random bypass traffic and mid-line reset.
module tb_rgb2ycbcr_csc;
    localparam int LAT = 3;
    localparam int W   = 44;   // [43:28] due cycle, [27] bit-exact flag, [26:0] expected DPo

    localparam int WHITE = 0;
    localparam int BLACK = 1;
    localparam int RED   = 2;
    localparam int GREEN = 3;
    localparam int BLUE  = 4;

    localparam logic [23:0] RGB_T [5] = '{24'hFFFFFF, 24'h000000, 24'hFF0000,
                                          24'h00FF00, 24'h0000FF};
    localparam logic [23:0] FULL_T [5] = '{{8'd255, 8'd128, 8'd128},
                                           {8'd0,   8'd128, 8'd128},
                                           {8'd77,  8'd85,  8'd255},
                                           {8'd149, 8'd43,  8'd21},
                                           {8'd29,  8'd255, 8'd107}};
    localparam logic [23:0] STUDIO_T [5] = '{{8'd235, 8'd128, 8'd128},
                                             {8'd16,  8'd128, 8'd128},
                                             {8'd82,  8'd90,  8'd240},
                                             {8'd144, 8'd54,  8'd34},
                                             {8'd41,  8'd240, 8'd110}};

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        range_sel;
    logic [26:0] DPi;
    logic [26:0] DPo;
    logic        active;

    rgb2ycbcr_csc #(.LAT(LAT)) dut (
        .clk(clk), .rst(rst), .enable(enable), .range_sel(range_sel),
        .DPi(DPi), .DPo(DPo), .active(active)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    logic cur_en;
    logic cur_rs;
    logic m_vs_prev = 1'b1;
    logic m_act = 1'b0;
    logic m_rng = 1'b0;

    task automatic chk(input string name, input logic [26:0] got, input logic [26:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, got, want);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic push_drive(input logic [26:0] dp, input logic [23:0] e0, input logic [23:0] e1);
        logic [26:0] e;
        logic        full;
        @(negedge clk);
        DPi       = dp;
        enable    = cur_en;
        range_sel = cur_rs;
        if (dp[26] && !m_vs_prev) begin
            m_act = cur_en;
            m_rng = cur_rs;
        end
        m_vs_prev = dp[26];
        if (m_act) begin
            e    = {dp[26:24], m_rng ? e1 : e0};
            full = 1'b0;
        end else begin
            e    = dp;
            full = 1'b1;
        end
        exp_q.push_back({16'(cyc + LAT), full, e});
    endtask

    task automatic drive_px(input logic vs, input logic hs, input logic de, input int idx);
        push_drive({vs, hs, de, RGB_T[idx]}, FULL_T[idx], STUDIO_T[idx]);
    endtask

    task automatic drive_raw(input logic [26:0] dp);
        push_drive(dp, 24'h0, 24'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        DPi = 27'h4000000;
        exp_q.delete();
        m_vs_prev = 1'b1;
        m_act     = 1'b0;
        m_rng     = 1'b0;
        #1;
        chk("midreset_dpo", DPo, 27'h0);
        chk("midreset_active", 27'(active), 27'h0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [W-1:0] e;
        forever begin
            @(posedge clk);
            #1;
            while (exp_q.size() > 0 && exp_q[0][43:28] <= 16'(cyc)) begin
                e = exp_q.pop_front();
                if (e[43:28] != 16'(cyc)) begin
                    checks++;
                    errors++;
                    $display("FAIL sched: entry due %0d seen at cycle %0d", e[43:28], cyc);
                end else if (e[27]) begin
                    chk("bypass", DPo, e[26:0]);
                end else begin
                    chk("sync", 27'(DPo[26:24]), 27'(e[26:24]));
                    if (e[24]) chk("pixel", 27'(DPo[23:0]), 27'(e[23:0]));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] r;
        rst       = 1'b1;
        cur_en    = 1'b1;
        cur_rs    = 1'b0;
        enable    = 1'b1;
        range_sel = 1'b0;
        DPi       = 27'h4000000;
        repeat (3) @(negedge clk);
        chk("reset_dpo", DPo, 27'h0);
        chk("reset_active", 27'(active), 27'h0);
        rst = 1'b0;

        // vsync already high at reset release: no frame start, stays in bypass
        drive_raw({3'b111, 24'h123456});
        drive_raw({3'b101, 24'hA5C3E1});
        drive_raw({3'b001, 24'h0F0F0F});
        drive_raw({3'b010, 24'hFEDCBA});
        chk("no_edge_active", 27'(active), 27'h0);

        // full-range frame
        drive_px(1'b1, 1'b0, 1'b0, BLACK);
        drive_px(1'b0, 1'b0, 1'b0, BLACK);
        drive_px(1'b0, 1'b0, 1'b1, WHITE);
        drive_px(1'b0, 1'b0, 1'b1, BLACK);
        drive_px(1'b0, 1'b0, 1'b1, RED);
        drive_px(1'b0, 1'b0, 1'b1, GREEN);
        drive_px(1'b0, 1'b0, 1'b1, BLUE);
        drive_px(1'b0, 1'b1, 1'b0, BLACK);
        chk("frame_active", 27'(active), 27'h1);

        // controls change mid-frame: ignored until the next vsync edge
        cur_en = 1'b0;
        cur_rs = 1'b1;
        drive_px(1'b0, 1'b0, 1'b1, RED);
        drive_px(1'b0, 1'b0, 1'b1, GREEN);
        chk("midframe_active", 27'(active), 27'h1);
        drive_px(1'b1, 1'b0, 1'b0, BLACK);

        // bypass frame with random bus contents
        for (int i = 0; i < 1000; i++) begin
            r = $urandom;
            drive_raw(r[26:0]);
        end
        chk("bypass_active", 27'(active), 27'h0);

        // studio-range frame, then reset in the middle of a line
        cur_en = 1'b1;
        cur_rs = 1'b1;
        drive_px(1'b0, 1'b0, 1'b0, BLACK);
        drive_px(1'b1, 1'b0, 1'b0, BLACK);
        drive_px(1'b0, 1'b0, 1'b1, RED);
        drive_px(1'b0, 1'b0, 1'b1, WHITE);
        drive_px(1'b0, 1'b0, 1'b1, BLACK);
        drive_px(1'b0, 1'b0, 1'b1, GREEN);
        drive_px(1'b0, 1'b0, 1'b1, BLUE);
        drive_px(1'b0, 1'b0, 1'b1, RED);
        drive_px(1'b0, 1'b0, 1'b1, RED);
        do_reset();

        // after reset: bypass until a fresh vsync edge
        drive_raw({3'b001, 24'hFF0000});
        drive_raw({3'b001, 24'h00FF00});
        drive_raw({3'b011, 24'h0000FF});
        drive_raw({3'b000, 24'h808080});
        chk("post_reset_active", 27'(active), 27'h0);
        cur_rs = 1'b0;
        drive_px(1'b1, 1'b0, 1'b0, BLACK);
        drive_px(1'b0, 1'b0, 1'b1, WHITE);
        drive_px(1'b0, 1'b0, 1'b1, RED);
        drive_px(1'b0, 1'b0, 1'b0, BLACK);
        chk("reframe_active", 27'(active), 27'h1);

        repeat (LAT + 2) @(negedge clk);
        chk("drain", 27'(exp_q.size()), 27'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
